// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: FIFO entry layout, trigger levels
// and the character-timeout state encoding.
package uart_pkg;

    typedef struct packed {
        logic       bi;
        logic       fe;
        logic       pe;
        logic [7:0] data;
    } rx_entry_t;

    typedef enum logic [1:0] {
        RX_TL_1  = 2'b00,
        RX_TL_4  = 2'b01,
        RX_TL_8  = 2'b10,
        RX_TL_14 = 2'b11
    } rx_tl_e;

    typedef enum logic [1:0] {
        RX_TO_IDLE,
        RX_TO_COUNT,
        RX_TO_EXPIRED
    } rx_to_state_e;

    // Trigger threshold in entries, clamped so a shallow FIFO can still reach it.
    function automatic int unsigned rx_tl_threshold(input rx_tl_e tl, input int unsigned depth);
        int unsigned t;
        case (tl)
            RX_TL_1: t = 1;
            RX_TL_4: t = 4;
            RX_TL_8: t = 8;
            default: t = 14;
        endcase
        return (t > depth) ? depth : t;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// RX FIFO storage: DEPTH x 11-bit entries with a registered head-of-queue read.
module uart_rx_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                       pclk,
    input  logic                       presetn,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_ptr,
    input  rx_entry_t                  wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_ptr_next,
    input  logic                       empty_next,
    output rx_entry_t                  head
);

    rx_entry_t mem [DEPTH];

    always_ff @(posedge pclk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    // A write landing on the next head slot bypasses the array so the head is never stale.
    always_ff @(posedge pclk) begin
        if (!presetn || empty_next)
            head <= '0;
        else if (wr_en && (wr_ptr == rd_ptr_next))
            head <= wr_data;
        else
            head <= mem[rd_ptr_next];
    end

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// Receive-side FIFO sequencing, line status (DR/OE/PE/FE/BI/RXFE) and the
// RX-data-available / character-timeout interrupt requests.
module uart_rx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned TIMEOUT_TICKS = 640
) (
    input  logic                     pclk,
    input  logic                     presetn,
    input  logic                     fen,
    input  logic                     rxfrst,
    input  logic [1:0]               rxtl,
    input  logic                     sample_edge,
    input  logic                     receive_done,
    input  logic [7:0]               rsr_data,
    input  logic                     parity_error,
    input  logic                     frame_error,
    input  logic                     rbr_rd,
    input  logic                     lsr_rd,
    output logic [7:0]               rbr_data,
    output logic                     lsr_dr,
    output logic                     lsr_oe,
    output logic                     lsr_pe,
    output logic                     lsr_fe,
    output logic                     lsr_bi,
    output logic                     lsr_rxfe,
    output logic [$clog2(DEPTH):0]   rx_level,
    output logic                     rda_irq,
    output logic                     cti_irq
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_TICKS);

    logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [CW-1:0] count_n, err_cnt, eff_depth, rx_thresh;
    logic [TW-1:0] to_cnt;
    logic          fen_q, flush, empty, full;
    logic          push_ok, pop_ok, overrun, activity, push_err, pop_err;
    rx_entry_t     in_entry, head;
    rx_to_state_e  to_state, to_state_n;

    assign in_entry  = {frame_error & (rsr_data == 8'h00), frame_error, parity_error, rsr_data};
    assign eff_depth = fen ? CW'(DEPTH) : CW'(1);
    assign rx_thresh = CW'(rx_tl_threshold(rx_tl_e'(rxtl), DEPTH));
    assign empty     = (rx_level == '0);
    assign full      = (rx_level == eff_depth);
    assign flush     = rxfrst | (fen ^ fen_q);

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign pop_ok    = rbr_rd & ~empty & ~flush;
    assign push_ok   = receive_done & (~full | rbr_rd) & ~flush;
    assign overrun   = receive_done & full & ~rbr_rd & ~flush;
    assign activity  = push_ok | pop_ok;
    assign push_err  = push_ok & (in_entry.pe | in_entry.fe | in_entry.bi);
    assign pop_err   = pop_ok & (head.pe | head.fe | head.bi);

    always_comb begin
        wr_ptr_n = wr_ptr;
        rd_ptr_n = rd_ptr;
        count_n  = rx_level;
        if (flush) begin
            wr_ptr_n = '0;
            rd_ptr_n = '0;
            count_n  = '0;
        end else begin
            if (push_ok) wr_ptr_n = wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr_n = rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_n = rx_level + CW'(1);
                2'b01:   count_n = rx_level - CW'(1);
                default: count_n = rx_level;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_level <= '0;
            err_cnt  <= '0;
            lsr_oe   <= 1'b0;
            fen_q    <= fen;
        end else begin
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            rx_level <= count_n;
            fen_q    <= fen;
            if (flush)
                err_cnt <= '0;
            else if (push_err && !pop_err)
                err_cnt <= err_cnt + CW'(1);
            else if (pop_err && !push_err)
                err_cnt <= err_cnt - CW'(1);
            if (flush)
                lsr_oe <= 1'b0;
            else if (overrun)
                lsr_oe <= 1'b1;
            else if (lsr_rd)
                lsr_oe <= 1'b0;
        end
    end

    uart_rx_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .pclk        (pclk),
        .presetn     (presetn),
        .wr_en       (push_ok),
        .wr_ptr      (wr_ptr),
        .wr_data     (in_entry),
        .rd_ptr_next (rd_ptr_n),
        .empty_next  (count_n == '0),
        .head        (head)
    );

    assign rbr_data = head.data;
    assign lsr_pe   = head.pe;
    assign lsr_fe   = head.fe;
    assign lsr_bi   = head.bi;
    assign lsr_dr   = ~empty;
    assign lsr_rxfe = fen & (err_cnt != '0);
    assign rda_irq  = fen ? (rx_level >= rx_thresh) : ~empty;

    always_ff @(posedge pclk) begin
        if (!presetn)
            to_state <= RX_TO_IDLE;
        else
            to_state <= to_state_n;
    end

    always_ff @(posedge pclk) begin
        if (!presetn || (to_state != RX_TO_COUNT) || activity)
            to_cnt <= '0;
        else if (sample_edge)
            to_cnt <= to_cnt + TW'(1);
    end

    always_comb begin
        to_state_n = to_state;
        if (!fen || flush) begin
            to_state_n = RX_TO_IDLE;
        end else begin
            case (to_state)
                RX_TO_IDLE:
                    if (!empty) to_state_n = RX_TO_COUNT;
                RX_TO_COUNT:
                    if (empty)
                        to_state_n = RX_TO_IDLE;
                    else if (!activity && sample_edge && (to_cnt == TW'(TIMEOUT_TICKS - 1)))
                        to_state_n = RX_TO_EXPIRED;
                RX_TO_EXPIRED:
                    if (empty)
                        to_state_n = RX_TO_IDLE;
                    else if (activity)
                        to_state_n = RX_TO_COUNT;
                default:
                    to_state_n = RX_TO_IDLE;
            endcase
        end
    end

    always_comb begin
        cti_irq = (to_state == RX_TO_EXPIRED);
    end

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Directed bench for uart_rx_fifo_ctrl: ordering, overrun, break/error status,
// trigger level, character timeout and holding-register mode.
module tb_uart_rx_fifo_ctrl;

    logic       pclk = 1'b0;
    logic       presetn = 1'b0;
    logic       fen = 1'b1;
    logic       rxfrst = 1'b0;
    logic [1:0] rxtl = 2'b00;
    logic       sample_edge = 1'b0;
    logic       receive_done = 1'b0;
    logic [7:0] rsr_data = 8'h00;
    logic       parity_error = 1'b0;
    logic       frame_error = 1'b0;
    logic       rbr_rd = 1'b0;
    logic       lsr_rd = 1'b0;
    logic [7:0] rbr_data;
    logic       lsr_dr, lsr_oe, lsr_pe, lsr_fe, lsr_bi, lsr_rxfe;
    logic [4:0] rx_level;
    logic       rda_irq, cti_irq;

    int total = 0;
    int bad = 0;

    always #5 pclk = ~pclk;

    uart_rx_fifo_ctrl #(.DEPTH(16), .TIMEOUT_TICKS(640)) dut (
        .pclk(pclk), .presetn(presetn), .fen(fen), .rxfrst(rxfrst), .rxtl(rxtl),
        .sample_edge(sample_edge), .receive_done(receive_done), .rsr_data(rsr_data),
        .parity_error(parity_error), .frame_error(frame_error), .rbr_rd(rbr_rd),
        .lsr_rd(lsr_rd), .rbr_data(rbr_data), .lsr_dr(lsr_dr), .lsr_oe(lsr_oe),
        .lsr_pe(lsr_pe), .lsr_fe(lsr_fe), .lsr_bi(lsr_bi), .lsr_rxfe(lsr_rxfe),
        .rx_level(rx_level), .rda_irq(rda_irq), .cti_irq(cti_irq)
    );

    // Stimulus helpers: each drives one clock edge and returns on the following negedge.
    task automatic push(input logic [7:0] d, input logic p, input logic f);
        @(negedge pclk);
        receive_done = 1'b1; rsr_data = d; parity_error = p; frame_error = f;
        @(negedge pclk);
        receive_done = 1'b0; parity_error = 1'b0; frame_error = 1'b0;
    endtask

    task automatic pop();
        @(negedge pclk); rbr_rd = 1'b1;
        @(negedge pclk); rbr_rd = 1'b0;
    endtask

    task automatic flush_fifo();
        @(negedge pclk); rxfrst = 1'b1;
        @(negedge pclk); rxfrst = 1'b0;
    endtask

    task automatic test_reset();
        presetn = 1'b0;
        repeat (2) @(negedge pclk);
        total++; if (rbr_data !== 8'h00) begin bad++; $display("FAIL reset_rbr got=%h exp=00", rbr_data); end
        total++; if (rx_level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", rx_level); end
        total++; if ({lsr_dr, lsr_oe, lsr_pe, lsr_fe, lsr_bi, lsr_rxfe} !== 6'b0) begin bad++; $display("FAIL reset_lsr got=%b exp=000000", {lsr_dr, lsr_oe, lsr_pe, lsr_fe, lsr_bi, lsr_rxfe}); end
        total++; if ({rda_irq, cti_irq} !== 2'b00) begin bad++; $display("FAIL reset_irq got=%b exp=00", {rda_irq, cti_irq}); end
        presetn = 1'b1;
    endtask

    task automatic test_order();
        push(8'h41, 1'b0, 1'b0);
        push(8'h42, 1'b0, 1'b0);
        push(8'h43, 1'b0, 1'b0);
        total++; if (rx_level !== 5'd3) begin bad++; $display("FAIL order_level got=%0d exp=3", rx_level); end
        total++; if (rbr_data !== 8'h41 || lsr_dr !== 1'b1) begin bad++; $display("FAIL order_0 got=%h/%b exp=41/1", rbr_data, lsr_dr); end
        pop();
        total++; if (rbr_data !== 8'h42 || lsr_dr !== 1'b1) begin bad++; $display("FAIL order_1 got=%h/%b exp=42/1", rbr_data, lsr_dr); end
        pop();
        total++; if (rbr_data !== 8'h43 || lsr_dr !== 1'b1) begin bad++; $display("FAIL order_2 got=%h/%b exp=43/1", rbr_data, lsr_dr); end
        pop();
        total++; if (rbr_data !== 8'h00 || lsr_dr !== 1'b0) begin bad++; $display("FAIL order_empty got=%h/%b exp=00/0", rbr_data, lsr_dr); end
        pop();
        total++; if (rx_level !== 5'd0) begin bad++; $display("FAIL underflow_level got=%0d exp=0", rx_level); end
    endtask

    task automatic test_overrun();
        flush_fifo();
        for (int i = 0; i < 17; i++) push(8'(i + 1), 1'b0, 1'b0);
        total++; if (rx_level !== 5'd16) begin bad++; $display("FAIL ovr_level got=%0d exp=16", rx_level); end
        total++; if (lsr_oe !== 1'b1) begin bad++; $display("FAIL ovr_oe_set got=%b exp=1", lsr_oe); end
        total++; if (rbr_data !== 8'h01) begin bad++; $display("FAIL ovr_head got=%h exp=01", rbr_data); end
        @(negedge pclk); lsr_rd = 1'b1;
        @(negedge pclk); lsr_rd = 1'b0;
        total++; if (lsr_oe !== 1'b0) begin bad++; $display("FAIL ovr_oe_clr got=%b exp=0", lsr_oe); end
        @(negedge pclk);
        receive_done = 1'b1; rsr_data = 8'hAA; rbr_rd = 1'b1;
        @(negedge pclk);
        receive_done = 1'b0; rbr_rd = 1'b0;
        total++; if (rx_level !== 5'd16 || lsr_oe !== 1'b0 || rbr_data !== 8'h02) begin bad++; $display("FAIL full_pushpop got=%0d/%b/%h exp=16/0/02", rx_level, lsr_oe, rbr_data); end
        @(negedge pclk);
        receive_done = 1'b1; rsr_data = 8'hBB; lsr_rd = 1'b1;
        @(negedge pclk);
        receive_done = 1'b0; lsr_rd = 1'b0;
        total++; if (lsr_oe !== 1'b1 || rbr_data !== 8'h02) begin bad++; $display("FAIL ovr_set_wins got=%b/%h exp=1/02", lsr_oe, rbr_data); end
        flush_fifo();
        total++; if (rx_level !== 5'd0 || lsr_oe !== 1'b0 || rbr_data !== 8'h00) begin bad++; $display("FAIL rxfrst got=%0d/%b/%h exp=0/0/00", rx_level, lsr_oe, rbr_data); end
    endtask

    task automatic test_break();
        push(8'h00, 1'b0, 1'b1);
        push(8'h55, 1'b0, 1'b0);
        total++; if ({lsr_bi, lsr_fe, lsr_pe, lsr_rxfe} !== 4'b1101) begin bad++; $display("FAIL brk_head got=%b exp=1101", {lsr_bi, lsr_fe, lsr_pe, lsr_rxfe}); end
        pop();
        total++; if ({lsr_bi, lsr_fe, lsr_rxfe} !== 3'b000 || rbr_data !== 8'h55) begin bad++; $display("FAIL brk_after got=%b/%h exp=000/55", {lsr_bi, lsr_fe, lsr_rxfe}, rbr_data); end
        flush_fifo();
    endtask

    task automatic test_trigger();
        rxtl = 2'b10;
        for (int i = 0; i < 7; i++) push(8'h30, 1'b0, 1'b0);
        total++; if (rda_irq !== 1'b0) begin bad++; $display("FAIL trig_7 got=%b exp=0", rda_irq); end
        push(8'h31, 1'b0, 1'b0);
        total++; if (rda_irq !== 1'b1) begin bad++; $display("FAIL trig_8 got=%b exp=1", rda_irq); end
        pop();
        total++; if (rda_irq !== 1'b0) begin bad++; $display("FAIL trig_pop got=%b exp=0", rda_irq); end
        flush_fifo();
        rxtl = 2'b00;
    endtask

    task automatic test_timeout();
        push(8'h77, 1'b0, 1'b0);
        @(negedge pclk);
        total++; if (cti_irq !== 1'b0) begin bad++; $display("FAIL cti_start got=%b exp=0", cti_irq); end
        sample_edge = 1'b1;
        repeat (639) @(negedge pclk);
        total++; if (cti_irq !== 1'b0) begin bad++; $display("FAIL cti_639 got=%b exp=0", cti_irq); end
        @(negedge pclk);
        sample_edge = 1'b0;
        total++; if (cti_irq !== 1'b1) begin bad++; $display("FAIL cti_640 got=%b exp=1", cti_irq); end
        pop();
        total++; if (cti_irq !== 1'b0 || lsr_dr !== 1'b0) begin bad++; $display("FAIL cti_clear got=%b/%b exp=0/0", cti_irq, lsr_dr); end
    endtask

    task automatic test_holding();
        fen = 1'b0;
        repeat (2) @(negedge pclk);
        push(8'h11, 1'b0, 1'b0);
        push(8'h22, 1'b0, 1'b0);
        total++; if (lsr_oe !== 1'b1 || rbr_data !== 8'h11) begin bad++; $display("FAIL hold_ovr got=%b/%h exp=1/11", lsr_oe, rbr_data); end
        total++; if (rx_level !== 5'd1 || rda_irq !== 1'b1) begin bad++; $display("FAIL hold_level got=%0d/%b exp=1/1", rx_level, rda_irq); end
        @(negedge pclk);
        receive_done = 1'b1; rsr_data = 8'h33; presetn = 1'b0;
        @(negedge pclk);
        receive_done = 1'b0;
        total++; if (rbr_data !== 8'h00 || rx_level !== 5'd0 || {lsr_dr, lsr_oe, rda_irq, cti_irq} !== 4'b0) begin bad++; $display("FAIL hold_reset got=%h/%0d/%b exp=00/0/0000", rbr_data, rx_level, {lsr_dr, lsr_oe, rda_irq, cti_irq}); end
        presetn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_order();
        test_overrun();
        test_break();
        test_trigger();
        test_timeout();
        test_holding();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
